// File: rtl/dmem_responder_if.sv
// Valid/ready request/response bundle between the memory stage and the data-memory responder.
`default_nettype none

interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// Y86-64 data-memory responder: one outstanding 8-byte little-endian access,
// fixed programmable latency, bounds-checked. Revision 1.0.
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          write_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic          ready_q;
  logic          valid_q;
  logic [63:0]   rdata_q;
  logic          error_q;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          access_err;
  logic          do_access;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;

  // 65-bit sum so an address near 2^64 cannot wrap back into range.
  assign access_err = ({1'b0, addr_q} + 65'd7) >= 65'(DEPTH_BYTES);
  assign do_access  = (state == WAIT) && (cnt == '0);
  assign base       = addr_q[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  // Storage is deliberately not reset; a write only happens on the WAIT->RESP edge.
  always_ff @(posedge clk_i) begin
    if (do_access && write_q && !access_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            write_q <= bus.req_write_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
            cnt     <= CW'(LATENCY - 1);
            ready_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state   <= RESP;
            valid_q <= 1'b1;
            error_q <= access_err;
            rdata_q <= (!write_q && !access_err) ? rd_word : '0;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          rdata_q <= '0;
          error_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_error_o = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY 2 main instance, 1 and 4 for throughput).
`default_nettype none

module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus2 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus4 ();

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus2));
  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));
  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(4)) dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4));

  // Waits (bounded) for the edge at which bus2 accepts the held request; leaves us #1 past it.
  task automatic wait_accept(output bit ok);
    logic r;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      r = bus2.req_ready_o;
      @(posedge clk); #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full transaction on bus2 with rsp_ready held high; lat = edges from accept to rsp_valid, -1 on timeout.
  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                     output logic [63:0] rd, output logic er, output int lat);
    bit ok;
    rd  = 64'hDEAD_DEAD_DEAD_DEAD;
    er  = 1'bx;
    lat = -1;
    bus2.req_write_i = wr;
    bus2.req_addr_i  = a;
    bus2.req_wdata_i = wd;
    bus2.rsp_ready_i = 1'b1;
    bus2.req_valid_i = 1'b1;
    wait_accept(ok);
    bus2.req_valid_i = 1'b0;
    if (ok) begin
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (bus2.rsp_valid_o) begin
          rd  = bus2.rsp_rdata_o;
          er  = bus2.rsp_error_o;
          lat = n;
          break;
        end
      end
      if (lat > 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    bus2.req_valid_i = 0; bus2.req_write_i = 0; bus2.req_addr_i = 0; bus2.req_wdata_i = 0; bus2.rsp_ready_i = 0;
    bus1.req_valid_i = 0; bus1.req_write_i = 0; bus1.req_addr_i = 0; bus1.req_wdata_i = 0; bus1.rsp_ready_i = 0;
    bus4.req_valid_i = 0; bus4.req_write_i = 0; bus4.req_addr_i = 0; bus4.req_wdata_i = 0; bus4.rsp_ready_i = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus2.rsp_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle_valid cyc%0d: got %b want 0", i, bus2.rsp_valid_o);
      end
    end
    vectors++;
    if (bus2.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus2.req_ready_o); end
    vectors++;
    if (bus2.rsp_rdata_o !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", bus2.rsp_rdata_o); end
    vectors++;
    if (bus2.rsp_error_o !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", bus2.rsp_error_o); end
    vectors++;
    if (bus1.req_ready_o !== 1'b1 || bus4.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_l1_l4: got %b/%b want 1/1", bus1.req_ready_o, bus4.req_ready_o);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h10, 64'h1122334455667788, rd, er, lat);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL wr10_latency: got %0d want 2", lat); end
    vectors++;
    if (er !== 1'b0) begin miscompares++; $display("FAIL wr10_error: got %b want 0", er); end
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL wr10_rdata: got %h want 0", rd); end
    txn(1'b1, 64'h18, 64'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b0 || lat !== 2) begin miscompares++; $display("FAIL wr18: got err %b lat %0d want 0/2", er, lat); end
    txn(1'b0, 64'h10, 64'h0, rd, er, lat);
    vectors++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      miscompares++; $display("FAIL rd10: got %h err %b want 1122334455667788 err 0", rd, er);
    end
    txn(1'b0, 64'h12, 64'h0, rd, er, lat);
    vectors++;
    if (rd !== 64'h0000112233445566 || er !== 1'b0) begin
      miscompares++; $display("FAIL rd12_unaligned: got %h err %b want 0000112233445566 err 0", rd, er);
    end
  endtask

  task automatic test_bounds();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h0, 64'h0123456789ABCDEF, rd, er, lat);
    vectors++;
    if (er !== 1'b0) begin miscompares++; $display("FAIL wr0_error: got %b want 0", er); end
    txn(1'b1, 64'h3F8, 64'hCAFEF00DDEADBEEF, rd, er, lat);
    vectors++;
    if (er !== 1'b0) begin miscompares++; $display("FAIL wr3f8_error: got %b want 0", er); end
    txn(1'b0, 64'h3F8, 64'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b0 || rd !== 64'hCAFEF00DDEADBEEF) begin
      miscompares++; $display("FAIL rd3f8_top: got %h err %b want cafef00ddeadbeef err 0", rd, er);
    end
    txn(1'b0, 64'h3F9, 64'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      miscompares++; $display("FAIL rd3f9_oob: got %h err %b want 0 err 1", rd, er);
    end
    txn(1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hAAAAAAAAAAAAAAAA, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      miscompares++; $display("FAIL wr_overflow: got %h err %b want 0 err 1", rd, er);
    end
    txn(1'b0, 64'h0, 64'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b0 || rd !== 64'h0123456789ABCDEF) begin
      miscompares++; $display("FAIL rd0_nowrap: got %h err %b want 0123456789abcdef err 0", rd, er);
    end
    txn(1'b0, 64'h3F8, 64'h0, rd, er, lat);
    vectors++;
    if (rd !== 64'hCAFEF00DDEADBEEF) begin
      miscompares++; $display("FAIL rd3f8_after_overflow: got %h want cafef00ddeadbeef", rd);
    end
  endtask

  task automatic test_backpressure();
    bit ok; bit seen;
    logic [63:0] rd; logic er; int lat;
    seen = 1'b0;
    bus2.req_write_i = 1'b0;
    bus2.req_addr_i  = 64'h10;
    bus2.req_wdata_i = 64'h0;
    bus2.rsp_ready_i = 1'b0;
    bus2.req_valid_i = 1'b1;
    wait_accept(ok);
    bus2.req_valid_i = 1'b0;
    for (int n = 0; n < 20 && ok && !seen; n++) begin
      @(posedge clk); #1;
      seen = bus2.rsp_valid_o;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL bp_response_timeout: got none want rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus2.rsp_valid_o !== 1'b1 || bus2.rsp_rdata_o !== 64'h1122334455667788 ||
          bus2.rsp_error_o !== 1'b0 || bus2.req_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cyc%0d: got v%b d%h e%b r%b want v1 d1122334455667788 e0 r0",
                 i, bus2.rsp_valid_o, bus2.rsp_rdata_o, bus2.rsp_error_o, bus2.req_ready_o);
      end
      if (i == 1) begin
        bus2.req_write_i = 1'b1;
        bus2.req_addr_i  = 64'h18;
        bus2.req_wdata_i = 64'hFFFFFFFFFFFFFFFF;
        bus2.req_valid_i = 1'b1;
      end else if (i == 2) begin
        bus2.req_valid_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus2.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus2.rsp_valid_o !== 1'b0 || bus2.req_ready_o !== 1'b1 || bus2.rsp_rdata_o !== 64'h0) begin
      miscompares++;
      $display("FAIL bp_release: got v%b r%b d%h want v0 r1 d0", bus2.rsp_valid_o, bus2.req_ready_o, bus2.rsp_rdata_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus2.req_ready_o !== 1'b1 || bus2.rsp_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_pulse_ignored cyc%0d: got r%b v%b want r1 v0", i, bus2.req_ready_o, bus2.rsp_valid_o);
      end
    end
    txn(1'b0, 64'h18, 64'h0, rd, er, lat);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL bp_no_write: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h20, 64'h1234, rd, er, lat);
    bus2.req_write_i = 1'b1;
    bus2.req_addr_i  = 64'h20;
    bus2.req_wdata_i = 64'h5555555555555555;
    bus2.rsp_ready_i = 1'b1;
    bus2.req_valid_i = 1'b1;
    wait_accept(ok);
    bus2.req_valid_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus2.req_ready_o !== 1'b0 || !ok) begin
      miscompares++; $display("FAIL mid_wait_busy: got ready %b accepted %b want 0/1", bus2.req_ready_o, ok);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus2.req_ready_o !== 1'b1 || bus2.rsp_valid_o !== 1'b0 ||
        bus2.rsp_rdata_o !== 64'h0 || bus2.rsp_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got r%b v%b d%h e%b want r1 v0 d0 e0",
               bus2.req_ready_o, bus2.rsp_valid_o, bus2.rsp_rdata_o, bus2.rsp_error_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 64'h20, 64'h0, rd, er, lat);
    vectors++;
    if (rd !== 64'h1234 || er !== 1'b0) begin
      miscompares++; $display("FAIL rd20_after_reset: got %h err %b want 1234 err 0", rd, er);
    end
  endtask

  task automatic test_throughput();
    int q1[$];
    int q4[$];
    bus1.req_write_i = 1'b0; bus1.req_addr_i = 64'h0; bus1.rsp_ready_i = 1'b1; bus1.req_valid_i = 1'b1;
    bus4.req_write_i = 1'b0; bus4.req_addr_i = 64'h0; bus4.rsp_ready_i = 1'b1; bus4.req_valid_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (bus1.req_valid_i && bus1.req_ready_o) q1.push_back(cyc);
      if (bus4.req_valid_i && bus4.req_ready_o) q4.push_back(cyc);
      @(posedge clk); #1;
    end
    bus1.req_valid_i = 1'b0;
    bus4.req_valid_i = 1'b0;
    vectors++;
    if (q1.size() < 5 || q4.size() < 5) begin
      miscompares++; $display("FAIL tput_count: got %0d/%0d accepts want >=5/>=5", q1.size(), q4.size());
    end
    for (int i = 1; i < q1.size() && i < 5; i++) begin
      vectors++;
      if (q1[i] - q1[i-1] !== 3) begin
        miscompares++; $display("FAIL tput_lat1 gap%0d: got %0d want 3", i, q1[i] - q1[i-1]);
      end
    end
    for (int i = 1; i < q4.size() && i < 5; i++) begin
      vectors++;
      if (q4[i] - q4[i-1] !== 6) begin
        miscompares++; $display("FAIL tput_lat4 gap%0d: got %0d want 6", i, q4[i] - q4[i-1]);
      end
    end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bounds();
    test_backpressure();
    test_reset_mid_wait();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the memory-access stage of the Y86-64 CPU over a valid/ready request/response interface.
- Services one 8-byte little-endian read or write at a time, with a programmable fixed latency and bounds checking.
- Drives the read data that becomes valM and the status that becomes dmem_error.
- Single outstanding transaction; sits between the memory stage and the data RAM storage.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; valid byte addresses are 0..DEPTH_BYTES-1.
LATENCY, 2, cycles from request acceptance edge to the edge raising rsp_valid_o; legal range >=1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_n_i  input  1  asynchronous active-low reset
req_valid_i  input  1  request present
req_ready_o  output  1  responder can accept a request
req_write_i  input  1  1 = write, 0 = read
req_addr_i  input  64  byte address (valE)
req_wdata_i  input  64  write data (valA)
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  requester accepts the response
rsp_rdata_o  output  64  read data (valM); 0 for writes and errors
rsp_error_o  output  1  address out of range (dmem_error)

Behaviour:
- Reset (asserting rst_n_i low, asynchronous):
  - State = IDLE.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, req_ready_o=1, latency counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready_o = 1 only in IDLE.
  - rsp_valid_o = 1 only in RESP.
- IDLE:
  - If req_valid_i=1, accept at this edge: latch write, addr, wdata; cnt = LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt != 0: cnt--, stay in WAIT.
  - If cnt == 0: go to RESP and, at that same edge, perform the access and register the outputs.
  - Net effect: a request accepted at edge k shows rsp_valid_o=1 after edge k+LATENCY.
- Access rules:
  - err = (addr + 7 >= DEPTH_BYTES), computed at 65-bit width so 64-bit overflow is detected; no wrap-around.
  - Read, no error: rdata = {mem[a+7], …, mem[a]} (little-endian).
  - Write, no error: mem[a+i] = wdata[8i+7:8i] for i = 0..7; rdata = 0.
  - Any error: memory unchanged; rdata = 0; rsp_error_o = 1.
- RESP:
  - rsp_valid_o, rsp_rdata_o and rsp_error_o are held stable until rsp_ready_i=1 at a clock edge.
  - On that edge go to IDLE and clear rsp_valid_o, rsp_rdata_o and rsp_error_o to 0.
- req_valid_i is ignored outside IDLE. No queueing; the requester must hold its request until it sees req_ready_o.
- Minimum request-to-request period with rsp_ready_i held at 1 is LATENCY+2 cycles:
  - accept at edge k;
  - RESP entered at edge k+LATENCY;
  - response handshake at edge k+LATENCY+1;
  - next accept at edge k+LATENCY+2.
- Reset during WAIT: the transaction is discarded and a pending write is never performed.
- Reset during RESP: the response is dropped. A write already performed remains in memory.
- Address alignment is not required: any address with addr+7 < DEPTH_BYTES is legal.

Test Plan:
1. Reset, then release with no requests → req_ready_o=1; rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0 held indefinitely.
2. LATENCY=2:
   - Write 0x1122334455667788 to 0x10, accepted at edge k → rsp_valid_o high after edge k+2, error=0, rdata=0.
   - Write 0 to 0x18.
   - Read 0x10 → 0x1122334455667788.
   - Read 0x12 → 0x0000112233445566.
3. Bounds, DEPTH_BYTES=1024:
   - Read 0x3F8 → error=0.
   - Read 0x3F9 → error=1, rdata=0.
   - Write 0xAAAA… to 0xFFFFFFFFFFFFFFFC → error=1; a following read of 0x0 returns unchanged data (no wrap).
4. Backpressure:
   - Hold rsp_ready_i=0 for 5 cycles in RESP → rsp_valid_o, rdata and error stable; req_ready_o=0; a req_valid_i pulse in that window is not accepted.
   - Raise rsp_ready_i → IDLE on the next edge.
5. Reset mid-WAIT:
   - Write 0x5555… to 0x20 (which holds 0x1234), pull rst_n_i low one cycle after acceptance → outputs return to reset values immediately (asynchronously).
   - A later read of 0x20 returns 0x1234.
6. Throughput, LATENCY=1 and LATENCY=4, rsp_ready_i=1, req_valid_i held high → acceptances spaced exactly 3 and 6 cycles apart.
